// File: rtl/bird_pkg.sv
// Shared types and defaults for the bird frame sequencer.
// FSM state encoding plus the default frame and floor constants.
package bird_pkg;

    localparam int Y_W                   = 7;
    localparam int FLOOR_Y_DEFAULT       = 116;
    localparam int TICK_DIV_DEFAULT      = 833333;
    localparam int HOLDOFF_TICKS_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_WAIT,
        ST_STEP,
        ST_ERASE,
        ST_DRAW,
        ST_DEAD
    } state_t;

endpackage

// File: rtl/bird_frame_sequencer_key_press_detect.sv
// Two-flop synchroniser for an active-low push button plus a one-cycle
// pulse on the 1->0 edge of the synchronised level.
module key_press_detect (
    input  logic clk,
    input  logic resetLow,
    input  logic key,
    output logic press
);

    // [0],[1]: synchroniser, [2]: previous synchronised level
    logic [2:0] sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; buttons idle high, so the chain resets to 1 to avoid a
    // phantom press when reset is released.
    always_ff @(posedge clk or negedge resetLow) begin
        if (!resetLow) sync <= 3'b111;
        else           sync <= {sync[1:0], key};
    end

    assign press = sync[2] & ~sync[1];

endmodule

// File: rtl/bird_frame_sequencer.sv
// Frame controller for the bird motion datapath: frame tick, drop/flap strobe,
// erase/draw plot sequencing and game-over detection. Optional: FLAP_HOLDOFF_EN.
module bird_frame_sequencer
    import bird_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int FLOOR_Y  = FLOOR_Y_DEFAULT
`ifdef FLAP_HOLDOFF_EN
    , parameter int HOLDOFF_TICKS = HOLDOFF_TICKS_DEFAULT
`endif
) (
    input  logic           clk,
    input  logic           resetLow,
    input  logic           start_key,
    input  logic           flap_key,
    input  logic [Y_W-1:0] y_pos,
    input  logic           plot_done,
    output logic           drop_en,
    output logic           flap_active,
    output logic           old_or_current,
    output logic           phys_resetLow,
    output logic           plot_req,
    output logic           plot_erase,
    output logic           game_over,
    output logic           frame_overrun
);

    localparam int                 CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [Y_W-1:0]     FLOOR_VAL = Y_W'(FLOOR_Y);

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick_wrap;
    logic             tick_pend;
    logic             flap_pend;
    logic             start_press;
    logic             flap_press;
    logic             holdoff_clear;
    logic             flap_accept;

    key_press_detect u_start_key (
        .clk      (clk),
        .resetLow (resetLow),
        .key      (start_key),
        .press    (start_press)
    );

    key_press_detect u_flap_key (
        .clk      (clk),
        .resetLow (resetLow),
        .key      (flap_key),
        .press    (flap_press)
    );

    assign tick_wrap = (state != ST_IDLE) && (state != ST_RST) && (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetLow) begin
        if (!resetLow)                               tick_cnt <= '0;
        else if (state == ST_IDLE || state == ST_RST) tick_cnt <= '0;
        else if (tick_wrap)                          tick_cnt <= '0;
        else                                         tick_cnt <= tick_cnt + 1'b1;
    end

`ifdef FLAP_HOLDOFF_EN
    localparam int HO_W = (HOLDOFF_TICKS < 1) ? 1 : $clog2(HOLDOFF_TICKS + 1);
    logic [HO_W-1:0] holdoff;

    always_ff @(posedge clk or negedge resetLow) begin
        if (!resetLow)                          holdoff <= '0;
        else if (state == ST_RST)               holdoff <= '0;
        else if (state == ST_STEP && flap_active) holdoff <= HO_W'(HOLDOFF_TICKS);
        else if (tick_wrap && holdoff != '0)    holdoff <= holdoff - 1'b1;
    end

    assign holdoff_clear = (holdoff == '0);
`else
    assign holdoff_clear = 1'b1;
`endif

    // A press during STEP is kept for the following frame.
    assign flap_accept = flap_press && holdoff_clear &&
                         (state inside {ST_WAIT, ST_STEP, ST_ERASE, ST_DRAW});

    always_ff @(posedge clk or negedge resetLow) begin
        if (!resetLow) begin
            state          <= ST_IDLE;
            drop_en        <= 1'b0;
            flap_active    <= 1'b0;
            old_or_current <= 1'b1;
            phys_resetLow  <= 1'b1;
            plot_req       <= 1'b0;
            plot_erase     <= 1'b0;
            game_over      <= 1'b0;
            frame_overrun  <= 1'b0;
            tick_pend      <= 1'b0;
            flap_pend      <= 1'b0;
        end else begin
            // A tick landing while STEP consumes the previous one is a fresh frame.
            if (tick_wrap) begin
                tick_pend <= 1'b1;
                if (tick_pend && state != ST_STEP) frame_overrun <= 1'b1;
            end
            if (flap_accept) flap_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start_press) begin
                        state         <= ST_RST;
                        phys_resetLow <= 1'b0;
                    end
                end
                ST_RST: begin
                    state         <= ST_WAIT;
                    phys_resetLow <= 1'b1;
                    tick_pend     <= 1'b0;
                    flap_pend     <= 1'b0;
                end
                ST_WAIT: begin
                    if (tick_pend) begin
                        state       <= ST_STEP;
                        drop_en     <= 1'b1;
                        flap_active <= flap_pend;
                    end
                end
                ST_STEP: begin
                    state          <= ST_ERASE;
                    drop_en        <= 1'b0;
                    flap_active    <= 1'b0;
                    if (!tick_wrap)   tick_pend <= 1'b0;
                    if (!flap_accept) flap_pend <= 1'b0;
                    old_or_current <= 1'b0;
                    plot_erase     <= 1'b1;
                    plot_req       <= 1'b1;
                end
                ST_ERASE: begin
                    // Request stays up: the plotter takes the new attributes as the draw job.
                    if (plot_done) begin
                        state          <= ST_DRAW;
                        old_or_current <= 1'b1;
                        plot_erase     <= 1'b0;
                    end
                end
                ST_DRAW: begin
                    if (plot_done) begin
                        plot_req <= 1'b0;
                        if (y_pos == FLOOR_VAL) begin
                            state     <= ST_DEAD;
                            game_over <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_DEAD: begin
                    if (start_press) begin
                        state         <= ST_RST;
                        game_over     <= 1'b0;
                        phys_resetLow <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
